// File: rtl/midi_byte_parser.sv
`timescale 1ns/1ps
// midi_byte_parser
// Turns a stream of received UART bytes into MIDI message fields. It tracks
// running status and message position, reports real-time bytes on their own
// strobe, abandons partial messages after an idle timeout and counts framing
// errors.
//
// Ports
//   reg_clk      : clock, all logic on the rising edge
//   reset        : synchronous active-high reset
//   rx_valid     : one-cycle strobe, rx_data/rx_err hold a received byte
//   rx_data      : received byte
//   rx_err       : framing error, qualified by rx_valid
//   byteready    : one-cycle pulse, cur_status/midibyte_nr/midi_in_data are new
//   cur_status   : active (running) status byte, 8'h00 = none
//   midibyte_nr  : 0 = status byte, 1..n = data byte position
//   midi_in_data : byte being reported
//   rt_valid     : one-cycle pulse for a real-time byte (F8-FF)
//   rt_data      : real-time byte
//   sysex_end    : one-cycle pulse when a sysex message terminates or aborts
//   err_cnt      : framing-error count, saturates at 255
//
// state  | meaning
// IDLE   | no active status, data bytes are discarded
// CHAN   | channel message running status (80-EF)
// SYSCOM | system common message (F1-F6) in progress
// SYSEX  | system exclusive (F0) in progress
module midi_byte_parser #(
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic       reg_clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       byteready,
    output logic [7:0] cur_status,
    output logic [7:0] midibyte_nr,
    output logic [7:0] midi_in_data,
    output logic       rt_valid,
    output logic [7:0] rt_data,
    output logic       sysex_end,
    output logic [7:0] err_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {IDLE, CHAN, SYSCOM, SYSEX} state_t;

    state_t           state;
    logic [1:0]       msg_len;
    logic [TMR_W-1:0] idle_tmr;
    logic             clear_pend;
    logic [7:0]       len_ext;
    logic [7:0]       nr_sat;

    // Number of data bytes that follow a status byte (F0 handled separately).
    function automatic logic [1:0] len_of(input logic [7:0] s);
        logic [1:0] n;
        n = 2'd2;
        if (s[7:5] == 3'b110) begin
            n = 2'd1;
        end else if (s[7:4] == 4'hF) begin
            case (s)
                8'hF1, 8'hF3: n = 2'd1;
                8'hF2:        n = 2'd2;
                default:      n = 2'd0;
            endcase
        end
        return n;
    endfunction

    assign len_ext = {6'd0, msg_len};
    assign nr_sat  = (midibyte_nr == 8'hFF) ? 8'hFF : midibyte_nr + 8'd1;

    always_ff @(posedge reg_clk) begin
        if (reset) begin
            state        <= IDLE;
            msg_len      <= 2'd0;
            idle_tmr     <= '0;
            clear_pend   <= 1'b0;
            byteready    <= 1'b0;
            cur_status   <= 8'h00;
            midibyte_nr  <= 8'h00;
            midi_in_data <= 8'h00;
            rt_valid     <= 1'b0;
            rt_data      <= 8'h00;
            sysex_end    <= 1'b0;
            err_cnt      <= 8'h00;
        end else begin
            byteready <= 1'b0;
            rt_valid  <= 1'b0;
            sysex_end <= 1'b0;

            // A completed system message shows its status with the final
            // byteready, then drops to "none" on the following cycle.
            if (clear_pend) begin
                cur_status <= 8'h00;
                clear_pend <= 1'b0;
            end

            if (rx_valid && rx_err) begin
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
                midibyte_nr <= 8'h00;
                idle_tmr    <= '0;
                if (state == SYSEX || state == SYSCOM) begin
                    state      <= IDLE;
                    cur_status <= 8'h00;
                end
                if (state == SYSEX) begin
                    sysex_end <= 1'b1;
                end
            end else if (rx_valid && rx_data >= 8'hF8) begin
                // Real-time bytes are transparent: the idle timer is frozen.
                rt_valid <= 1'b1;
                rt_data  <= rx_data;
            end else if (rx_valid) begin
                idle_tmr <= TMR_LOAD;
                if (!rx_data[7]) begin
                    case (state)
                        CHAN: begin
                            byteready    <= 1'b1;
                            midi_in_data <= rx_data;
                            midibyte_nr  <= (midibyte_nr >= len_ext) ? 8'd1 : midibyte_nr + 8'd1;
                        end
                        SYSCOM: begin
                            if (midibyte_nr < len_ext) begin
                                byteready    <= 1'b1;
                                midi_in_data <= rx_data;
                                midibyte_nr  <= midibyte_nr + 8'd1;
                                if (midibyte_nr + 8'd1 == len_ext) begin
                                    state      <= IDLE;
                                    clear_pend <= 1'b1;
                                end
                            end
                        end
                        SYSEX: begin
                            byteready    <= 1'b1;
                            midi_in_data <= rx_data;
                            midibyte_nr  <= nr_sat;
                        end
                        default: ;
                    endcase
                end else if (rx_data == 8'hF7) begin
                    if (state == SYSEX) begin
                        byteready    <= 1'b1;
                        midi_in_data <= rx_data;
                        midibyte_nr  <= nr_sat;
                        sysex_end    <= 1'b1;
                        state        <= IDLE;
                        clear_pend   <= 1'b1;
                    end
                end else begin
                    // New status 80-F6; a sysex in progress is implicitly ended.
                    if (state == SYSEX) begin
                        sysex_end <= 1'b1;
                    end
                    cur_status   <= rx_data;
                    midibyte_nr  <= 8'h00;
                    byteready    <= 1'b1;
                    midi_in_data <= rx_data;
                    msg_len      <= len_of(rx_data);
                    clear_pend   <= 1'b0;
                    if (rx_data < 8'hF0) begin
                        state <= CHAN;
                    end else if (rx_data == 8'hF0) begin
                        state <= SYSEX;
                    end else if (len_of(rx_data) == 2'd0) begin
                        state      <= IDLE;
                        clear_pend <= 1'b1;
                    end else begin
                        state <= SYSCOM;
                    end
                end
            end else if (idle_tmr != '0) begin
                idle_tmr <= idle_tmr - TMR_ONE;
                if (idle_tmr == TMR_ONE) begin
                    if (state == CHAN && midibyte_nr != 8'h00 && midibyte_nr < len_ext) begin
                        midibyte_nr <= 8'h00;
                    end
                    if (state == SYSEX) begin
                        sysex_end  <= 1'b1;
                        state      <= IDLE;
                        cur_status <= 8'h00;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_byte_parser.sv
`timescale 1ns/1ps
module tb_midi_byte_parser;

    localparam int TO = 40;

    logic       reg_clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       byteready;
    logic [7:0] cur_status;
    logic [7:0] midibyte_nr;
    logic [7:0] midi_in_data;
    logic       rt_valid;
    logic [7:0] rt_data;
    logic       sysex_end;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_status;
    int         m_cnt;
    logic [7:0] m_data;
    int         m_err;

    midi_byte_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .reg_clk      (reg_clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_err       (rx_err),
        .byteready    (byteready),
        .cur_status   (cur_status),
        .midibyte_nr  (midibyte_nr),
        .midi_in_data (midi_in_data),
        .rt_valid     (rt_valid),
        .rt_data      (rt_data),
        .sysex_end    (sysex_end),
        .err_cnt      (err_cnt)
    );

    always #5 reg_clk = ~reg_clk;

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int msg_len(input logic [7:0] s);
        if ((s >= 8'h80 && s <= 8'hBF) || (s >= 8'hE0 && s <= 8'hEF) || s == 8'hF2) return 2;
        if ((s >= 8'hC0 && s <= 8'hDF) || s == 8'hF1 || s == 8'hF3) return 1;
        return 0;
    endfunction

    // Expected reaction to one received byte, straight from the message rules.
    task automatic model_step(input logic [7:0] b, input logic e,
                              output logic br, output logic [7:0] st,
                              output logic se, output logic rt);
        br = 1'b0; se = 1'b0; rt = 1'b0; st = 8'h00;
        if (e) begin
            if (m_err < 255) m_err++;
            se = (m_status == 8'hF0);
            if (m_status >= 8'hF0) m_status = 8'h00;
            m_cnt = 0;
        end else if (b >= 8'hF8) begin
            rt = 1'b1;
        end else if (b < 8'h80) begin
            if (m_status == 8'hF0) begin
                if (m_cnt < 255) m_cnt++;
                br = 1'b1; st = 8'hF0;
            end else if (m_status >= 8'h80 && m_status < 8'hF0) begin
                m_cnt = (m_cnt >= msg_len(m_status)) ? 1 : m_cnt + 1;
                br = 1'b1; st = m_status;
            end else if (m_status > 8'hF0 && m_cnt < msg_len(m_status)) begin
                m_cnt++;
                br = 1'b1; st = m_status;
                if (m_cnt == msg_len(m_status)) m_status = 8'h00;
            end
        end else if (b == 8'hF7) begin
            if (m_status == 8'hF0) begin
                if (m_cnt < 255) m_cnt++;
                br = 1'b1; st = 8'hF0; se = 1'b1;
                m_status = 8'h00;
            end
        end else begin
            se = (m_status == 8'hF0);
            m_status = b;
            m_cnt = 0;
            br = 1'b1; st = b;
            if (b > 8'hF0 && msg_len(b) == 0) m_status = 8'h00;
        end
        if (br) m_data = b;
        if (!br) st = m_status;
    endtask

    task automatic do_reset();
        @(negedge reg_clk);
        reset = 1'b1; rx_valid = 1'b0; rx_err = 1'b0;
        @(negedge reg_clk);
        reset = 1'b0;
        m_status = 8'h00; m_cnt = 0; m_data = 8'h00; m_err = 0;
    endtask

    // Presents one byte; returns #1 after the edge that samples it.
    task automatic send(input logic [7:0] b, input logic e);
        @(negedge reg_clk);
        rx_valid = 1'b1; rx_data = b; rx_err = e;
        @(posedge reg_clk);
        #1;
        rx_valid = 1'b0; rx_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge reg_clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h90; rx_err = 1'b0;
        repeat (3) @(posedge reg_clk);
        #1;
        checks++; if (byteready !== 1'b0) begin errors++; $display("FAIL reset_byteready: got %b want 0", byteready); end
        checks++; if (cur_status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", cur_status); end
        checks++; if ({midibyte_nr, midi_in_data, rt_data, err_cnt} !== 32'h0) begin errors++; $display("FAIL reset_bytes: got %h want 0", {midibyte_nr, midi_in_data, rt_data, err_cnt}); end
        checks++; if ({rt_valid, sysex_end} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {rt_valid, sysex_end}); end
        do_reset();
    endtask

    task automatic test_note_on();
        logic [7:0] bytes [5] = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h50};
        int         nrs   [5] = '{0, 1, 2, 1, 2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(bytes[i], 1'b0);
            checks++; if (byteready !== 1'b1) begin errors++; $display("FAIL note_br[%0d]: got %b want 1", i, byteready); end
            checks++; if (cur_status !== 8'h90) begin errors++; $display("FAIL note_status[%0d]: got %h want 90", i, cur_status); end
            checks++; if (midibyte_nr !== 8'(nrs[i])) begin errors++; $display("FAIL note_nr[%0d]: got %0d want %0d", i, midibyte_nr, nrs[i]); end
            checks++; if (midi_in_data !== bytes[i]) begin errors++; $display("FAIL note_data[%0d]: got %h want %h", i, midi_in_data, bytes[i]); end
            @(posedge reg_clk); #1;
            checks++; if (byteready !== 1'b0) begin errors++; $display("FAIL note_pulse[%0d]: got %b want 0", i, byteready); end
        end
    endtask

    task automatic test_pc_rt();
        do_reset();
        send(8'hC5, 1'b0);
        checks++; if ({byteready, midibyte_nr} !== {1'b1, 8'd0}) begin errors++; $display("FAIL pc_status: got %b/%0d want 1/0", byteready, midibyte_nr); end
        send(8'h07, 1'b0);
        checks++; if ({byteready, midibyte_nr} !== {1'b1, 8'd1}) begin errors++; $display("FAIL pc_data1: got %b/%0d want 1/1", byteready, midibyte_nr); end
        send(8'hF8, 1'b0);
        checks++; if ({rt_valid, rt_data, byteready} !== {1'b1, 8'hF8, 1'b0}) begin errors++; $display("FAIL pc_rt: got %b/%h/%b want 1/f8/0", rt_valid, rt_data, byteready); end
        checks++; if ({cur_status, midibyte_nr} !== {8'hC5, 8'd1}) begin errors++; $display("FAIL pc_rt_hold: got %h/%0d want c5/1", cur_status, midibyte_nr); end
        send(8'h09, 1'b0);
        checks++; if ({byteready, midibyte_nr, cur_status} !== {1'b1, 8'd1, 8'hC5}) begin errors++; $display("FAIL pc_data2: got %b/%0d/%h want 1/1/c5", byteready, midibyte_nr, cur_status); end
    endtask

    task automatic test_sysex();
        logic [7:0] bytes [4] = '{8'hF0, 8'h43, 8'h10, 8'hF7};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(bytes[i], 1'b0);
            checks++; if ({byteready, midibyte_nr, cur_status, midi_in_data} !== {1'b1, 8'(i), 8'hF0, bytes[i]})
                begin errors++; $display("FAIL sysex[%0d]: got br=%b nr=%0d st=%h d=%h want 1/%0d/f0/%h", i, byteready, midibyte_nr, cur_status, midi_in_data, i, bytes[i]); end
            checks++; if (sysex_end !== (i == 3)) begin errors++; $display("FAIL sysex_end[%0d]: got %b want %b", i, sysex_end, i == 3); end
        end
        @(posedge reg_clk); #1;
        checks++; if (cur_status !== 8'h00) begin errors++; $display("FAIL sysex_clear: got %h want 00", cur_status); end
        send(8'h22, 1'b0);
        checks++; if (byteready !== 1'b0) begin errors++; $display("FAIL sysex_after: got %b want 0", byteready); end
    endtask

    task automatic test_sysex_saturate();
        int n_br = 0;
        do_reset();
        send(8'hF0, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            send(8'($urandom_range(0, 127)), 1'b0);
            if (byteready === 1'b1) n_br++;
            if (i == 254 || i == 255 || i == 300) begin
                checks++; if (midibyte_nr !== 8'((i > 255) ? 255 : i)) begin errors++; $display("FAIL sat_nr[%0d]: got %0d want %0d", i, midibyte_nr, (i > 255) ? 255 : i); end
            end
        end
        checks++; if (n_br != 300) begin errors++; $display("FAIL sat_count: got %0d want 300", n_br); end
    endtask

    task automatic test_idle_discard();
        do_reset();
        send(8'h3C, 1'b0);
        checks++; if ({byteready, cur_status} !== {1'b0, 8'h00}) begin errors++; $display("FAIL idle_discard: got %b/%h want 0/00", byteready, cur_status); end
    endtask

    task automatic test_timeout();
        int seen = 0;
        do_reset();
        send(8'h90, 1'b0); send(8'h3C, 1'b0);
        idle(TO + 2);
        send(8'h40, 1'b0);
        checks++; if ({byteready, midibyte_nr} !== {1'b1, 8'd1}) begin errors++; $display("FAIL timeout_chan: got %b/%0d want 1/1", byteready, midibyte_nr); end
        send(8'h90, 1'b0); send(8'h3C, 1'b0);
        idle(TO - 5);
        send(8'h40, 1'b0);
        checks++; if ({byteready, midibyte_nr} !== {1'b1, 8'd2}) begin errors++; $display("FAIL no_timeout_chan: got %b/%0d want 1/2", byteready, midibyte_nr); end
        send(8'hF0, 1'b0); send(8'h01, 1'b0);
        for (int i = 0; i < TO + 10; i++) begin
            @(posedge reg_clk); #1;
            if (sysex_end === 1'b1) seen++;
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL timeout_sysex_end: got %0d pulses want 1", seen); end
        checks++; if (cur_status !== 8'h00) begin errors++; $display("FAIL timeout_sysex_status: got %h want 00", cur_status); end
    endtask

    task automatic test_err();
        do_reset();
        send(8'h90, 1'b0); send(8'h3C, 1'b0);
        send(8'h55, 1'b1);
        checks++; if ({err_cnt, cur_status, midibyte_nr, byteready} !== {8'd1, 8'h90, 8'd0, 1'b0})
            begin errors++; $display("FAIL err_chan: got cnt=%0d st=%h nr=%0d br=%b want 1/90/0/0", err_cnt, cur_status, midibyte_nr, byteready); end
        send(8'h40, 1'b0);
        checks++; if ({byteready, midibyte_nr} !== {1'b1, 8'd1}) begin errors++; $display("FAIL err_resume: got %b/%0d want 1/1", byteready, midibyte_nr); end
        send(8'hF0, 1'b0); send(8'h12, 1'b0);
        send(8'h34, 1'b1);
        checks++; if ({sysex_end, cur_status, err_cnt} !== {1'b1, 8'h00, 8'd2}) begin errors++; $display("FAIL err_sysex: got %b/%h/%0d want 1/00/2", sysex_end, cur_status, err_cnt); end
        for (int i = 0; i < 258; i++) send(8'($urandom), 1'b1);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_sat: got %0d want 255", err_cnt); end
        do_reset();
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL err_reset: got %0d want 0", err_cnt); end
    endtask

    task automatic test_syscom();
        int se_seen = 0;
        do_reset();
        send(8'hB0, 1'b0); se_seen += int'(sysex_end);
        send(8'h07, 1'b0); se_seen += int'(sysex_end);
        send(8'hF2, 1'b0); se_seen += int'(sysex_end);
        checks++; if ({byteready, cur_status, midibyte_nr} !== {1'b1, 8'hF2, 8'd0}) begin errors++; $display("FAIL syscom_f2: got %b/%h/%0d want 1/f2/0", byteready, cur_status, midibyte_nr); end
        send(8'h10, 1'b0); se_seen += int'(sysex_end);
        checks++; if ({byteready, midibyte_nr, midi_in_data} !== {1'b1, 8'd1, 8'h10}) begin errors++; $display("FAIL syscom_d1: got %b/%0d/%h want 1/1/10", byteready, midibyte_nr, midi_in_data); end
        send(8'h20, 1'b0); se_seen += int'(sysex_end);
        checks++; if ({byteready, midibyte_nr, cur_status} !== {1'b1, 8'd2, 8'hF2}) begin errors++; $display("FAIL syscom_d2: got %b/%0d/%h want 1/2/f2", byteready, midibyte_nr, cur_status); end
        send(8'h30, 1'b0); se_seen += int'(sysex_end);
        checks++; if ({byteready, cur_status} !== {1'b0, 8'h00}) begin errors++; $display("FAIL syscom_surplus: got %b/%h want 0/00", byteready, cur_status); end
        checks++; if (se_seen != 0) begin errors++; $display("FAIL syscom_no_sysex_end: got %0d pulses want 0", se_seen); end
        send(8'hF6, 1'b0);
        checks++; if ({byteready, cur_status, midibyte_nr} !== {1'b1, 8'hF6, 8'd0}) begin errors++; $display("FAIL f6: got %b/%h/%0d want 1/f6/0", byteready, cur_status, midibyte_nr); end
        @(posedge reg_clk); #1;
        checks++; if (cur_status !== 8'h00) begin errors++; $display("FAIL f6_clear: got %h want 00", cur_status); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'hF0, 1'b0); send(8'h11, 1'b0);
        @(negedge reg_clk);
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h22;
        @(posedge reg_clk); #1;
        checks++; if ({byteready, sysex_end, cur_status, midibyte_nr} !== {2'b00, 16'h0}) begin errors++; $display("FAIL reset_mid: got %b/%b/%h/%0d want 0/0/00/0", byteready, sysex_end, cur_status, midibyte_nr); end
        rx_valid = 1'b0;
        @(posedge reg_clk); #1;
        checks++; if ({byteready, sysex_end} !== 2'b00) begin errors++; $display("FAIL reset_mid_after: got %b/%b want 0/0", byteready, sysex_end); end
        do_reset();
    endtask

    task automatic run_random(input int n, input int max_gap);
        logic [7:0] b;
        logic       e, ebr, ese, ert;
        logic [7:0] est;
        int         r;
        do_reset();
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            e = 1'b0;
            if (r < 45)      b = 8'($urandom_range(0, 127));
            else if (r < 63) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 70) b = 8'hF0;
            else if (r < 78) b = 8'($urandom_range(8'hF1, 8'hF7));
            else if (r < 90) b = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r < 94) begin b = 8'($urandom); e = 1'b1; end
            else             b = 8'hF7;
            model_step(b, e, ebr, est, ese, ert);
            send(b, e);
            checks++; if (byteready !== ebr) begin errors++; $display("FAIL rnd_br[%0d] byte %h err %b: got %b want %b", i, b, e, byteready, ebr); end
            checks++; if (sysex_end !== ese) begin errors++; $display("FAIL rnd_sysex_end[%0d] byte %h: got %b want %b", i, b, sysex_end, ese); end
            checks++; if (rt_valid !== ert) begin errors++; $display("FAIL rnd_rt_valid[%0d] byte %h: got %b want %b", i, b, rt_valid, ert); end
            if (ert) begin
                checks++; if (rt_data !== b) begin errors++; $display("FAIL rnd_rt_data[%0d]: got %h want %h", i, rt_data, b); end
            end
            checks++; if (cur_status !== est) begin errors++; $display("FAIL rnd_status[%0d] byte %h: got %h want %h", i, b, cur_status, est); end
            checks++; if (midibyte_nr !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_nr[%0d] byte %h: got %0d want %0d", i, b, midibyte_nr, m_cnt); end
            checks++; if (midi_in_data !== m_data) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, midi_in_data, m_data); end
            checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL rnd_err_cnt[%0d]: got %0d want %0d", i, err_cnt, m_err); end
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic test_random();
        run_random(1500, 3);
    endtask

    task automatic test_back_to_back();
        run_random(1000, 0);
    endtask

    initial begin
        m_status = 8'h00; m_cnt = 0; m_data = 8'h00; m_err = 0;
        test_reset();
        test_note_on();
        test_pc_rt();
        test_sysex();
        test_sysex_saturate();
        test_idle_discard();
        test_timeout();
        test_err();
        test_syscom();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
